mod_count_detector: RTL
=======================

# mod_count_detector

Multi-channel serial stream checker that tracks, per channel, the count of received ones modulo `ONE_MOD` and the count of received zeros modulo `ZERO_MOD`. It flags when both residues are zero. It generalises the even-ones/even-zeros detector to arbitrary moduli, N independent channels, input qualification, per-channel clear and frame-based pass/fail reporting. It sits behind serial front ends as a lightweight stream-integrity monitor.

## Interface
- `N_CH`, 4, number of independent channels (≥1)
- `ONE_MOD`, 2, modulus applied to the ones count (≥2)
- `ZERO_MOD`, 2, modulus applied to the zeros count (≥2)
- `CNT_W` (localparam), `$clog2(max(ONE_MOD,ZERO_MOD))`, residue width
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low reset
- `data_in` in N_CH: serial bit per channel
- `valid_in` in N_CH: qualifies `data_in[i]`; bit ignored when low
- `clear` in N_CH: synchronous per-channel residue clear
- `frame_end` in N_CH: marks the current cycle as the last of a frame
- `out` out N_CH: 1 when channel ones residue == 0 and zeros residue == 0
- `ones_res` out N_CH*CNT_W: per-channel ones residue, channel i at `[i*CNT_W +: CNT_W]`
- `zeros_res` out N_CH*CNT_W: per-channel zeros residue, same packing
- `frame_ok` out N_CH: registered frame verdict, held until the next verdict
- `frame_valid` out N_CH: one-cycle pulse, `frame_ok[i]` updated this cycle

## Operation
- Channels are fully independent. No cross-channel interaction.
- Per channel, on each rising edge, apply the first matching rule in this order:
  - `clear`: both residues go to 0. The bit is discarded, no verdict is produced and `frame_valid` stays low.
  - `valid_in`, `data_in=1`: ones residue increments, wrapping from `ONE_MOD-1` to 0.
  - `valid_in`, `data_in=0`: zeros residue increments, wrapping from `ZERO_MOD-1` to 0.
  - otherwise: hold.
- `frame_end` without `clear`:
  - The verdict includes the bit accepted in the same cycle, if any.
  - `frame_ok` ← (post-update ones residue == 0 && post-update zeros residue == 0).
  - `frame_valid` pulses.
  - Both residues then load 0, so the next frame starts clean.
- `frame_end` with `valid_in` low evaluates the current residues unchanged.
- `out` is a Moore output: combinational decode of registered residues only. There is no input-to-output path.
- Residues never take values ≥ their modulus. When `ONE_MOD` is not a power of two, the wrap compares explicitly against `MOD-1`.

## Timing
- Reset (`reset`=0, asynchronous, no clock needed):
  - residues = 0
  - `out` = all 1s (zero ones and zero zeros is a match)
  - `frame_ok` = 0
  - `frame_valid` = 0
- Reset release is synchronised externally. The first update occurs on the first rising edge with `reset`=1.
- `out`, `ones_res`, `zeros_res`: 1-cycle latency. They reflect a bit from the edge on which it was sampled.
- `frame_ok`/`frame_valid`: registered on the edge sampling `frame_end`, and visible in the following cycle.
  - `frame_valid` is high exactly one cycle per accepted `frame_end`.
  - Back-to-back `frame_end` gives back-to-back pulses. The second verdict covers a single-bit (or empty) frame.
  - An empty frame (residues 0, no bit) yields `frame_ok`=1.
- During the `frame_valid` cycle, `out` = 1 because residues were cleared. This is not an error.
- Reset asserted mid-frame discards the frame with no verdict.

## Structure
- Shared package `mod_count_pkg`:
  - `max_int` function
  - `CNT_W` derivation helper
  - residue-pair struct typedef (`ones`, `zeros`)
- Sub-module `mod_count_channel`: single-channel residue FSM plus frame verdict register, instantiated `N_CH` times in a generate loop. The top handles only port packing.
- Parameter legality (`MOD ≥ 2`, `N_CH ≥ 1`) is checked by elaboration-time assertion in the top.

## Test plan
- Reset: drive `reset`=0 mid-simulation between edges. Required response, immediately: `out`=4'b1111, all residues 0, `frame_ok`=0, `frame_valid`=0.
- Default moduli, ch0 `valid_in`=1, bits 1,0,1,0. Required `out[0]` after each edge: 0,0,0,1. `ones_res[0]` after each edge: 1,1,0,0.
- `ONE_MOD`=3, `ZERO_MOD`=4 instance, ch2 bits 1,1,1,0,0,0,0:
  - `ones_res` after the 1s: 1,2,0 (wrap)
  - `zeros_res` after the 0s: 1,2,3,0 (wrap)
  - `out[2]`=1 after the final edge
- Qualification and clear:
  - `valid_in` low for 5 cycles with toggling `data_in`: residues unchanged.
  - `clear` together with `valid_in`=1, `data_in`=1 at ones_res=1: residues 0, bit dropped, `out`=1.
- Frame verdicts on ch1 (default moduli):
  - Bits 1,1, then `frame_end` together with bit 0: `frame_ok[1]`=0, `frame_valid[1]` high 1 cycle, residues 0.
  - Next frame bits 0, then `frame_end` with bit 0: `frame_ok[1]`=1.
  - `frame_end` together with `clear`: no pulse.
- Channel isolation: random `$random` bits on all 4 channels for 40 cycles. Each channel's residues match a reference model, and activity on ch3 never perturbs ch0–ch2.

Source files
------------

// File: rtl/mod_count_pkg.sv
// Shared types and helpers for the modular ones/zeros stream checker.
package mod_count_pkg;

  // Width of the internal arithmetic used for residue updates; residues are
  // computed at this width and then narrowed to the channel's CNT_W.
  localparam int RES_W_MAX = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Residue width for a pair of moduli; never narrower than one bit.
  function automatic int cnt_width(input int one_mod, input int zero_mod);
    int m;
    m = max_int(one_mod, zero_mod);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  typedef struct packed {
    logic [RES_W_MAX-1:0] ones;
    logic [RES_W_MAX-1:0] zeros;
  } res_pair_t;

  // Per-edge action of a channel, in priority order clear > one > zero > hold.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_CLEAR = 2'd1,
    ACT_ONE   = 2'd2,
    ACT_ZERO  = 2'd3
  } chan_act_t;

endpackage

// File: rtl/mod_count_channel.sv
// Single channel: ones/zeros residue tracker plus frame verdict register.
//
// action    | meaning
// ----------+-----------------------------------------------------------
// ACT_HOLD  | no qualified bit, residues unchanged
// ACT_CLEAR | residues forced to 0, bit and any frame_end discarded
// ACT_ONE   | ones residue advances, wrapping at ONE_MOD-1
// ACT_ZERO  | zeros residue advances, wrapping at ZERO_MOD-1
//
// A frame_end (without clear) takes the verdict on the post-update residues
// and then restarts both residues at 0.
module mod_count_channel
  import mod_count_pkg::*;
#(
  parameter int ONE_MOD  = 2,
  parameter int ZERO_MOD = 2,
  parameter int CNT_W    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             valid_in,
  input  logic             clear,
  input  logic             frame_end,
  output logic             out,
  output logic [CNT_W-1:0] ones_res,
  output logic [CNT_W-1:0] zeros_res,
  output logic             frame_ok,
  output logic             frame_valid
);

  localparam logic [RES_W_MAX-1:0] ONE_LAST  = RES_W_MAX'(ONE_MOD - 1);
  localparam logic [RES_W_MAX-1:0] ZERO_LAST = RES_W_MAX'(ZERO_MOD - 1);
  localparam logic [RES_W_MAX-1:0] RES_ONE   = RES_W_MAX'(1);

  chan_act_t act;
  res_pair_t cur;
  res_pair_t nxt;
  logic      verdict;

  // Pick the single action for this edge; clear outranks any qualified bit.
  always_comb begin
    act = ACT_HOLD;
    if (clear) begin
      act = ACT_CLEAR;
    end else if (valid_in && data_in) begin
      act = ACT_ONE;
    end else if (valid_in) begin
      act = ACT_ZERO;
    end
  end

  // Post-update residues; explicit compare against MOD-1 keeps non-power-of-two moduli in range.
  always_comb begin
    cur.ones  = RES_W_MAX'(ones_res);
    cur.zeros = RES_W_MAX'(zeros_res);
    nxt       = cur;
    case (act)
      ACT_CLEAR: nxt = '0;
      ACT_ONE:   nxt.ones  = (cur.ones  == ONE_LAST)  ? '0 : cur.ones  + RES_ONE;
      ACT_ZERO:  nxt.zeros = (cur.zeros == ZERO_LAST) ? '0 : cur.zeros + RES_ONE;
      default:   nxt = cur;
    endcase
    verdict = (nxt.ones == '0) && (nxt.zeros == '0);
  end

  // Residue and verdict registers; frame_valid is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ones_res    <= '0;
      zeros_res   <= '0;
      frame_ok    <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (act == ACT_CLEAR) begin
        ones_res  <= '0;
        zeros_res <= '0;
      end else if (frame_end) begin
        frame_ok    <= verdict;
        frame_valid <= 1'b1;
        ones_res    <= '0;
        zeros_res   <= '0;
      end else begin
        ones_res  <= nxt.ones[CNT_W-1:0];
        zeros_res <= nxt.zeros[CNT_W-1:0];
      end
    end
  end

  // Moore match flag decoded from the registered residues only.
  always_comb begin
    out = (ones_res == '0) && (zeros_res == '0);
  end

endmodule

// File: rtl/mod_count_detector.sv
// N-channel modular ones/zeros stream checker; packs per-channel ports.
module mod_count_detector
  import mod_count_pkg::*;
#(
  parameter  int N_CH     = 4,
  parameter  int ONE_MOD  = 2,
  parameter  int ZERO_MOD = 2,
  localparam int CNT_W    = cnt_width(ONE_MOD, ZERO_MOD)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       data_in,
  input  logic [N_CH-1:0]       valid_in,
  input  logic [N_CH-1:0]       clear,
  input  logic [N_CH-1:0]       frame_end,
  output logic [N_CH-1:0]       out,
  output logic [N_CH*CNT_W-1:0] ones_res,
  output logic [N_CH*CNT_W-1:0] zeros_res,
  output logic [N_CH-1:0]       frame_ok,
  output logic [N_CH-1:0]       frame_valid
);

  // Reject illegal configurations at elaboration.
  if (N_CH < 1) begin : g_bad_n_ch
    $fatal(1, "mod_count_detector: N_CH must be at least 1");
  end
  if (ONE_MOD < 2) begin : g_bad_one_mod
    $fatal(1, "mod_count_detector: ONE_MOD must be at least 2");
  end
  if (ZERO_MOD < 2) begin : g_bad_zero_mod
    $fatal(1, "mod_count_detector: ZERO_MOD must be at least 2");
  end
  if (CNT_W >= RES_W_MAX) begin : g_bad_width
    $fatal(1, "mod_count_detector: moduli too large for residue arithmetic");
  end

  // One independent checker per channel.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    mod_count_channel #(
      .ONE_MOD  (ONE_MOD),
      .ZERO_MOD (ZERO_MOD),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .data_in     (data_in[i]),
      .valid_in    (valid_in[i]),
      .clear       (clear[i]),
      .frame_end   (frame_end[i]),
      .out         (out[i]),
      .ones_res    (ones_res[i*CNT_W +: CNT_W]),
      .zeros_res   (zeros_res[i*CNT_W +: CNT_W]),
      .frame_ok    (frame_ok[i]),
      .frame_valid (frame_valid[i])
    );
  end

endmodule
